pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, cycles checkpre_flush/ifid_flush stay high per accepted mispredict; legal range 1-3.
REQ-002 Parameter MC_MAX, default 64, maximum cycles spent in MC_WAIT before forced exit.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-006 id_rs1_en, id_rs2_en  in  1 each  source operand actually read.
REQ-007 ex_rd  in  5  destination index of the instruction in EX; ex_rd_en  in  1  EX writes ex_rd.
REQ-008 ex_is_load  in  1  EX instruction is a load.
REQ-009 ex_mc_start  in  1  multi-cycle operation entered EX this cycle; ex_mc_done  in  1  its result is ready.
REQ-010 mispredict  in  1  branch/jump check in EX found a wrong prediction.
REQ-011 pc_stall, ifid_stall  out  1 each  hold PC and IF/ID register.
REQ-012 ifid_flush  out  1  clear IF/ID register to NOP.
REQ-013 feedforward_stall  out  1  hold ID/EX register contents.
REQ-014 checkpre_flush  out  1  load NOP bubble into ID/EX register; takes priority over feedforward_stall at the ID/EX register.
REQ-015 exmem_bubble  out  1  insert NOP into EX/MEM register.
REQ-016 mc_err  out  1  sticky flag, MC_MAX timeout occurred.
REQ-017 stall_cycles  out  32  saturating count of cycles with pc_stall=1.
REQ-018 flush_events  out  16  saturating count of accepted mispredicts.

Function
REQ-019 FSM states RUN, MC_WAIT, FLUSH; the FLUSH down-counter and the MC_WAIT up-counter are each 8 bits.
REQ-020 Outputs SHALL be combinational functions of state and current inputs (same-cycle response); counters and mc_err are registered.
REQ-021 In RUN, events are prioritised mispredict > ex_mc_start > load-use; only the highest-priority event is acted on.
REQ-022 Load-use hazard = ex_is_load & ex_rd_en & ex_rd!=0 & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)).
REQ-023 RUN + load-use: assert pc_stall, ifid_stall and checkpre_flush for that cycle only; state remains RUN.
REQ-024 RUN + mispredict: assert checkpre_flush and ifid_flush that cycle; increment flush_events; if FLUSH_CYCLES>1, go to FLUSH with counter = FLUSH_CYCLES-1; otherwise stay in RUN.
REQ-025 FLUSH: assert checkpre_flush and ifid_flush and decrement the counter each cycle; go to RUN in the cycle the counter reaches 1; inputs are ignored in FLUSH.
REQ-026 RUN + ex_mc_start: go to MC_WAIT with counter = 0; no stall output in the start cycle unless ex_mc_done is also 1, in which case stay in RUN.
REQ-027 MC_WAIT, ex_mc_done=0: assert pc_stall, ifid_stall, feedforward_stall and exmem_bubble; increment the counter.
REQ-028 MC_WAIT, ex_mc_done=1: all outputs low that cycle; go to RUN.
REQ-029 MC_WAIT with counter == MC_MAX-1 and ex_mc_done=0: set mc_err; go to RUN next cycle.
REQ-030 Mispredict and load-use are ignored in MC_WAIT.
REQ-031 stall_cycles and flush_events SHALL hold at all-ones rather than wrap.

Reset
REQ-032 While rst=1 at posedge: state=RUN, FSM counters=0, stall_cycles=0, flush_events=0, mc_err=0.
REQ-033 While rst is high, all control outputs SHALL be 0 regardless of inputs; rst asserted in MC_WAIT or FLUSH aborts the operation with no residual stall or flush.

Verification
REQ-034 ex_is_load=1, ex_rd=5, ex_rd_en=1, id_rs2=5, id_rs2_en=1 -> one cycle of pc_stall=ifid_stall=checkpre_flush=1, then all low; stall_cycles=1.
REQ-035 Same as REQ-034 with ex_rd=0, or with id_rs2_en=0 -> no stall or flush asserted.
REQ-036 FLUSH_CYCLES=2, single-cycle mispredict -> checkpre_flush=ifid_flush=1 for exactly 2 cycles; flush_events=1.
REQ-037 ex_mc_start, then ex_mc_done 4 cycles later -> pc_stall=feedforward_stall=exmem_bubble=1 for 3 cycles, low in the done cycle; stall_cycles=3.
REQ-038 MC_MAX=8, ex_mc_start with ex_mc_done never asserted -> 8 stall cycles, mc_err=1, FSM back in RUN.
REQ-039 mispredict and load-use in the same cycle -> flush only, no pc_stall; rst pulsed mid-MC_WAIT -> outputs 0 and counters 0 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, mispredict flush sequencing
// and multi-cycle EX operation stalling with a timeout watchdog.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MC_MAX       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_en,
    input  logic        id_rs2_en,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_en,
    input  logic        ex_is_load,
    input  logic        ex_mc_start,
    input  logic        ex_mc_done,
    input  logic        mispredict,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        feedforward_stall,
    output logic        checkpre_flush,
    output logic        exmem_bubble,
    output logic        mc_err,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        RUN,
        MC_WAIT,
        FLUSH
    } state_t;

    localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MC_LAST    = 8'(MC_MAX - 1);

    state_t     state;
    logic [7:0] flush_cnt;
    logic [7:0] mc_cnt;
    logic       load_use;

    // Load-use hazard between the load in EX and the operands read in ID
    always_comb begin
        load_use = ex_is_load && ex_rd_en && (ex_rd != 5'd0) &&
                   ((id_rs1_en && (id_rs1 == ex_rd)) ||
                    (id_rs2_en && (id_rs2 == ex_rd)));
    end

    // Same-cycle control outputs from current state and inputs; forced low in reset
    always_comb begin
        pc_stall          = 1'b0;
        ifid_stall        = 1'b0;
        ifid_flush        = 1'b0;
        feedforward_stall = 1'b0;
        checkpre_flush    = 1'b0;
        exmem_bubble      = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mispredict) begin
                        checkpre_flush = 1'b1;
                        ifid_flush     = 1'b1;
                    end else if (ex_mc_start) begin
                        // start cycle itself never stalls
                    end else if (load_use) begin
                        pc_stall       = 1'b1;
                        ifid_stall     = 1'b1;
                        checkpre_flush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (!ex_mc_done) begin
                        pc_stall          = 1'b1;
                        ifid_stall        = 1'b1;
                        feedforward_stall = 1'b1;
                        exmem_bubble      = 1'b1;
                    end
                end
                FLUSH: begin
                    checkpre_flush = 1'b1;
                    ifid_flush     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, sequencing counters, sticky error and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= '0;
            mc_cnt       <= '0;
            mc_err       <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;

            case (state)
                RUN: begin
                    if (mispredict) begin
                        if (flush_events != '1)
                            flush_events <= flush_events + 16'd1;
                        if (FLUSH_CYCLES > 1) begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_INIT;
                        end
                    end else if (ex_mc_start && !ex_mc_done) begin
                        state  <= MC_WAIT;
                        mc_cnt <= '0;
                    end
                end
                MC_WAIT: begin
                    if (ex_mc_done) begin
                        state <= RUN;
                    end else begin
                        mc_cnt <= mc_cnt + 8'd1;
                        if (mc_cnt == MC_LAST) begin
                            mc_err <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 8'd1;
                    if (flush_cnt == 8'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
